// File: rtl/instr_mem_loader.sv
// Byte-stream loader: receives a length-prefixed, XOR-checksummed program image,
// writes it into instruction memory and holds the core in reset until verified.
module instr_mem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error
);

    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic [23:0]       shift;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   word_next;

    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_lo};
    // Word counter is one bit wider than the address so N == MAX_WORDS never wraps.
    assign word_next = word_cnt + 1'b1;

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state       <= IDLE;
            rx_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            len_lo      <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            csum        <= '0;
            shift       <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state       <= LEN_LO;
                        rx_ready    <= 1'b1;
                        cpu_reset_n <= 1'b0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        csum        <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        csum   <= csum ^ rx_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        csum    <= csum ^ rx_data;
                        n_words <= len_full[ADDR_W:0];
                        if ({1'b0, len_full} > 17'(MAX_WORDS)) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ rx_data;
                        shift    <= {rx_data, shift[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Write lands the cycle after the 4th byte; input keeps flowing.
                            mem_we    <= 1'b1;
                            mem_wdata <= {rx_data, shift};
                            mem_addr  <= word_cnt[ADDR_W-1:0];
                            word_cnt  <= word_next;
                            if (word_next == n_words) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frames plus random frames,
// compared every cycle against a frame-position reference model.
module tb_instr_mem_loader;

    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset_n;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .areset     (areset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset_n(cpu_reset_n),
        .done       (done),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame rather than any FSM state.
    bit                m_ready = 0, m_done = 0, m_err = 0, m_we = 0, m_accepted = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_wdata = '0, m_word = '0;
    logic [7:0]        m_x = '0;
    int                m_pos = 0, m_n = 0;

    task automatic model_byte(input logic [7:0] b);
        int k;
        m_x = m_x ^ b;
        if (m_pos == 0) begin
            m_n   = int'(b);
            m_pos = 1;
        end else if (m_pos == 1) begin
            m_n   = m_n + 256 * int'(b);
            m_pos = 2;
            if (m_n > MAX_WORDS) begin
                m_ready = 0;
                m_err   = 1;
            end
        end else if (m_pos < 2 + 4 * m_n) begin
            k = m_pos - 2;
            m_word[8*(k%4) +: 8] = b;
            if (k % 4 == 3) begin
                m_we    = 1;
                m_addr  = ADDR_W'(k / 4);
                m_wdata = m_word;
            end
            m_pos++;
        end else begin
            m_x     = m_x ^ b;
            m_ready = 0;
            if (b == m_x) m_done = 1;
            else          m_err  = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_accepted = 0;
        if (!areset) begin
            m_ready = 0; m_done = 0; m_err = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_pos = 0; m_n = 0; m_x = '0;
        end else begin
            m_we = 0;
            if (start && !m_ready) begin
                m_ready = 1; m_done = 0; m_err = 0;
                m_pos = 0; m_n = 0; m_x = '0;
            end else if (rx_valid && m_ready) begin
                m_accepted = 1;
                model_byte(rx_data);
            end
        end
    end

    // Per-cycle compare, plus a log of DUT writes for literal checks.
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       dut_mem[MAX_WORDS];

    initial forever begin
        @(negedge clk);
        check("rx_ready", 32'(rx_ready), 32'(m_ready));
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("cpu_reset_n", 32'(cpu_reset_n), 32'(m_done));
        if (m_we) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_we === 1'b1) begin
            wr_count++;
            last_addr          = mem_addr;
            dut_mem[mem_addr]  = mem_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        int guard;
        if (throttle) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!m_accepted && guard < 16);
        if (!m_accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted within %0d cycles", b, guard);
        end
    endtask

    // start_at >= 0 pulses start (which must be ignored) just before that byte.
    task automatic send_frame(input byte_q_t q, input bit throttle, input int start_at);
        foreach (q[i]) begin
            if (i == start_at) pulse_start();
            send_byte(q[i], throttle);
        end
        rx_valid = 1'b0;
    endtask

    task automatic build_frame(input int n, input bit bad, output byte_q_t q);
        logic [7:0]  x;
        logic [31:0] w;
        q = {};
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        x = q[0] ^ q[1];
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                for (int j = 0; j < 4; j++) begin
                    q.push_back(w[8*j +: 8]);
                    x = x ^ w[8*j +: 8];
                end
            end
            q.push_back(bad ? ~x : x);
        end
    endtask

    byte_q_t good_frame;
    byte_q_t frame;
    int      base;

    initial begin
        good_frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                       8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};

        // Reset, then idle with a stray valid byte.
        areset = 1'b0;
        tick(3);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        areset = 1'b1;
        base = wr_count;
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        tick(4);
        rx_valid = 1'b0;
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_writes", 32'(wr_count - base), 32'd0);

        // Good two-word load.
        base = wr_count;
        pulse_start();
        send_frame(good_frame, 1'b0, -1);
        tick(2);
        check("good_writes", 32'(wr_count - base), 32'd2);
        check("good_word0", dut_mem[0], 32'h00500093);
        check("good_word1", dut_mem[1], 32'h00100113);
        check("good_done", 32'(done), 32'd1);
        check("good_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        check("good_model_done", 32'(m_done), 32'd1);

        // Bad checksum: words still written, then ERR; restart clears error.
        frame = good_frame;
        frame[10] = 8'hC2;
        base = wr_count;
        pulse_start();
        send_frame(frame, 1'b0, -1);
        tick(2);
        check("badsum_writes", 32'(wr_count - base), 32'd2);
        check("badsum_error", 32'(error), 32'd1);
        check("badsum_done", 32'(done), 32'd0);
        check("badsum_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        pulse_start();
        check("restart_error", 32'(error), 32'd0);
        check("restart_rx_ready", 32'(rx_ready), 32'd1);

        // Oversize length (already armed by the restart above).
        base = wr_count;
        frame = '{8'h41, 8'h00};
        send_frame(frame, 1'b0, -1);
        tick(2);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_rx_ready", 32'(rx_ready), 32'd0);
        check("oversize_writes", 32'(wr_count - base), 32'd0);

        // Empty image with throttled input.
        base = wr_count;
        frame = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_frame(frame, 1'b1, -1);
        tick(2);
        check("empty_done", 32'(done), 32'd1);
        check("empty_writes", 32'(wr_count - base), 32'd0);

        // Full-size image of zeros: N=64, checksum 0x40.
        frame = '{8'h40, 8'h00};
        repeat (4 * MAX_WORDS) frame.push_back(8'h00);
        frame.push_back(8'h40);
        base = wr_count;
        pulse_start();
        send_frame(frame, 1'b0, -1);
        tick(2);
        check("full_writes", 32'(wr_count - base), 32'd64);
        check("full_last_addr", 32'(last_addr), 32'd63);
        check("full_done", 32'(done), 32'd1);

        // Reset mid-load, then a normal load.
        base = wr_count;
        frame = '{8'h02, 8'h00, 8'h93, 8'h00};
        pulse_start();
        send_frame(frame, 1'b0, -1);
        areset = 1'b0;
        tick(2);
        areset = 1'b1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("midrst_writes", 32'(wr_count - base), 32'd0);
        base = wr_count;
        pulse_start();
        send_frame(good_frame, 1'b0, -1);
        tick(2);
        check("reload_done", 32'(done), 32'd1);
        check("reload_writes", 32'(wr_count - base), 32'd2);
        check("reload_word1", dut_mem[1], 32'h00100113);

        // Random frames: sizes, throttling, corrupt checksums, oversize, ignored start.
        for (int t = 0; t < 12; t++) begin
            int  n;
            int  st;
            bit  bad;
            bit  thr;
            n   = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 300) : $urandom_range(0, 64);
            bad = ($urandom_range(0, 3) == 0);
            thr = $urandom_range(0, 1) == 1;
            build_frame(n, bad, frame);
            st  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, frame.size() - 1) : -1;
            tick($urandom_range(0, 3));
            pulse_start();
            send_frame(frame, thr, st);
            tick(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
